// File: rtl/multicycle_div_unit.sv
// rtl/multicycle_div_unit.sv - iterative restoring divider for MIPS DIV/DIVU
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   start, is_signed          request a divide (sampled in IDLE), 1 = DIV, 0 = DIVU
//   dividend, divisor         rs / rt operands, captured when start is accepted
//   flush                     abort the operation in flight
//   busy                      operation in flight (stall source for the hazard unit)
//   done                      one-cycle pulse when quotient/remainder update
//   quotient, remainder       LO / HI results, held until the next done
//   div_by_zero               qualifies the current results; divisor was 0
module multicycle_div_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] rem_r, quo_r, dsr_r;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [CW-1:0]    cnt_r;
    logic             sign_q_r, sign_r_r, dbz_r;
    logic             load, step, commit;
    logic             dsr_zero;
    logic [WIDTH-1:0] dvd_abs, dsr_abs;
    logic [WIDTH:0]   sh, tr;

    assign dsr_zero = (divisor == '0);
    assign dvd_abs  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dsr_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start && !flush) state_n = dsr_zero ? FIX : CALC;
            CALC: begin
                if (flush)                       state_n = IDLE;
                else if (cnt_r == CW'(N - 1))    state_n = FIX;
            end
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy   = (state != IDLE);
        load   = (state == IDLE) && start && !flush;
        step   = (state == CALC) && !flush;
        commit = (state == FIX)  && !flush;
    end

    // BITS_PER_CYCLE restoring steps; the subtract is one bit wider than the
    // operands so its top bit is the borrow (trial went negative -> restore).
    always_comb begin
        rem_n = rem_r;
        quo_n = quo_r;
        sh    = '0;
        tr    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            sh    = {rem_n, quo_n[WIDTH-1]};
            tr    = sh - {1'b0, dsr_r};
            quo_n = {quo_n[WIDTH-2:0], ~tr[WIDTH]};
            rem_n = tr[WIDTH] ? sh[WIDTH-1:0] : tr[WIDTH-1:0];
        end
    end

    // Datapath. On divide-by-zero the final results are preloaded directly
    // (all-ones quotient, raw dividend as remainder) and the sign fixes are
    // disabled, so FIX simply copies them out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_r       <= '0;
            quo_r       <= '0;
            dsr_r       <= '0;
            cnt_r       <= '0;
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            dbz_r       <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                quo_r    <= dsr_zero ? '1 : dvd_abs;
                rem_r    <= dsr_zero ? dividend : '0;
                dsr_r    <= dsr_abs;
                cnt_r    <= '0;
                sign_q_r <= !dsr_zero && is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                sign_r_r <= !dsr_zero && is_signed && dividend[WIDTH-1];
                dbz_r    <= dsr_zero;
            end
            if (step) begin
                rem_r <= rem_n;
                quo_r <= quo_n;
                cnt_r <= cnt_r + 1'b1;
            end
            if (commit) begin
                quotient    <= sign_q_r ? -quo_r : quo_r;
                remainder   <= sign_r_r ? -rem_r : rem_r;
                div_by_zero <= dbz_r;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_div_unit.sv
// tb/tb_multicycle_div_unit.sv - scoreboard bench for multicycle_div_unit (BITS_PER_CYCLE 1 and 4)
module tb_multicycle_div_unit;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;

    logic         busy [2];
    logic         done [2];
    logic [W-1:0] quo  [2];
    logic [W-1:0] rem  [2];
    logic         dbz  [2];

    logic [W-1:0] last_q [2];
    logic [W-1:0] last_r [2];
    logic         last_z [2];

    exp_t qs0[$];
    exp_t qs1[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int nsteps [2] = '{32, 8};

    multicycle_div_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_div1 (
        .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy[0]), .done(done[0]), .quotient(quo[0]), .remainder(rem[0]),
        .div_by_zero(dbz[0])
    );

    multicycle_div_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_div4 (
        .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy[1]), .done(done[1]), .quotient(quo[1]), .remainder(rem[1]),
        .div_by_zero(dbz[1])
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Reference: plain integer division in 64 bits (truncating, remainder takes
    // the dividend's sign), with the divide-by-zero rule applied first.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input int acc, input int n);
        exp_t   e;
        longint sa, sb;
        e.acc = acc;
        e.z   = (b == '0);
        e.lat = (b == '0) ? 1 : n + 1;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'b0, a});
                sb = longint'({32'b0, b});
            end
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
        end
        return e;
    endfunction

    // Monitor: compare every done against the head of the matching queue
    always @(negedge clock) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (done[d]) begin
                if ((d == 0 && qs0.size() == 0) || (d == 1 && qs1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d unexpected_done at cycle %0d", d, cyc);
                end else begin
                    e = (d == 0) ? qs0.pop_front() : qs1.pop_front();
                    chk($sformatf("dut%0d quotient", d), quo[d], e.q);
                    chk($sformatf("dut%0d remainder", d), rem[d], e.r);
                    chk($sformatf("dut%0d div_by_zero", d), W'(dbz[d]), W'(e.z));
                    chk($sformatf("dut%0d latency_cycle", d), W'(cyc), W'(e.acc + e.lat));
                    chk($sformatf("dut%0d busy_with_done", d), W'(busy[d]), '0);
                    last_q[d] = e.q;
                    last_r[d] = e.r;
                    last_z[d] = e.z;
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        qs0.push_back(model(a, b, s, cyc + 1, nsteps[0]));
        qs1.push_back(model(a, b, s, cyc + 1, nsteps[1]));
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qs0.size() != 0 || qs1.size() != 0) && t < 400) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (qs0.size() != 0 || qs1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d/%0d required=0/0", qs0.size(), qs1.size());
            qs0.delete();
            qs1.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s dut%0d busy", tag, d), W'(busy[d]), '0);
            chk($sformatf("%s dut%0d done", tag, d), W'(done[d]), '0);
            chk($sformatf("%s dut%0d quotient", tag, d), quo[d], '0);
            chk($sformatf("%s dut%0d remainder", tag, d), rem[d], '0);
            chk($sformatf("%s dut%0d div_by_zero", tag, d), W'(dbz[d]), '0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b;
        logic         s;
        int           acc;

        for (int d = 0; d < 2; d++) begin
            last_q[d] = '0;
            last_r[d] = '0;
            last_z[d] = 1'b0;
        end

        #2;
        chk_zero("reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Directed cases
        issue(32'd100, 32'd7, 1'b0);          drain();
        issue(-32'sd7, 32'd2, 1'b1);          drain();
        issue(32'd7, -32'sd2, 1'b1);          drain();
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); drain();
        issue(32'h0000_1234, 32'd0, 1'b1);    drain();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);    drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); drain();

        // Flush mid-CALC: no done, results held, next divide works
        issue(32'd1000, 32'd9, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        qs0.delete();
        qs1.delete();
        @(posedge clock);
        #1 flush = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("flush dut%0d busy", d), W'(busy[d]), '0);
            chk($sformatf("flush dut%0d quotient_held", d), quo[d], last_q[d]);
            chk($sformatf("flush dut%0d remainder_held", d), rem[d], last_r[d]);
            chk($sformatf("flush dut%0d dbz_held", d), W'(dbz[d]), W'(last_z[d]));
        end
        issue(32'd1000, 32'd9, 1'b0);  drain();

        // Flush together with start in IDLE: request dropped
        @(negedge clock);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        flush    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        flush = 1'b0;
        for (int d = 0; d < 2; d++)
            chk($sformatf("flush_start dut%0d busy", d), W'(busy[d]), '0);
        repeat (40) @(negedge clock);

        // Reset mid-CALC clears everything without a clock edge
        issue(32'd12345, 32'd67, 1'b0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b0;
        qs0.delete();
        qs1.delete();
        #1 chk_zero("midreset");
        for (int d = 0; d < 2; d++) begin
            last_q[d] = '0;
            last_r[d] = '0;
            last_z[d] = 1'b0;
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);

        // start held high: back-to-back divides every N+2 cycles
        a = $urandom;
        b = $urandom_range(1, 1000);
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        is_signed = 1'b1;
        start     = 1'b1;
        acc       = cyc + 1;
        for (int j = 0; j < 3; j++)  qs0.push_back(model(a, b, 1'b1, acc + 34 * j, nsteps[0]));
        for (int j = 0; j < 11; j++) qs1.push_back(model(a, b, 1'b1, acc + 10 * j, nsteps[1]));
        repeat (102) @(posedge clock);
        #1 start = 1'b0;
        drain();

        // Randomised operands
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = -W'($urandom_range(1, 15));
                3:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            issue(a, b, s);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
